// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv
//  Purpose  : Multi-cycle RV32M multiply/divide execute unit for the EX stage.
//             Shift-add multiply and restoring divide, one bit per cycle.
//             Divide-by-zero and signed overflow finish in one cycle.
//             The pipeline is held through stallreq_o while the unit iterates.
//  Ports    : clk, rst (sync, active-high)
//             start_i, op_i[2:0] (funct3), reg1_i, reg2_i, wd_i, flush_i
//             stallreq_o (comb), done_o, wdata_o, wd_o, wreg_o (registered)
//  Options  : BITTY_FAST_MUL_EN - multiplies use a single '*' and finish in
//             one cycle; divides are unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [XLEN-1:0]      reg1_i,
    input  logic [XLEN-1:0]      reg2_i,
    input  logic [REGADDR_W-1:0] wd_i,
    input  logic                 flush_i,
    output logic                 stallreq_o,
    output logic                 done_o,
    output logic [XLEN-1:0]      wdata_o,
    output logic [REGADDR_W-1:0] wd_o,
    output logic                 wreg_o
);

    localparam int            CW         = $clog2(XLEN);
    localparam logic [CW-1:0] c_cnt_last = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_op;
    logic [XLEN-1:0]        r_a;      // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0]      r_acc;    // {hi, lo} product or {rem, quo}
    logic                   r_sign;   // product / quotient negative
    logic                   r_rsign;  // remainder negative (follows dividend)
    logic                   r_done;
    logic [XLEN-1:0]        r_wdata;
    logic [REGADDR_W-1:0]   r_wd;
    logic                   w_stall;

    // Picks the low half for MUL, the high half for MULH/MULHSU/MULHU.
    function automatic logic [XLEN-1:0] f_sel_mul(input logic [1:0] op,
                                                  input logic [2*XLEN-1:0] p);
        return (op == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // ---------------------------------------------------------------- decode
    logic            w_start, w_sgn1, w_sgn2, w_neg1, w_neg2;
    logic [XLEN-1:0] w_mag1, w_mag2;
    logic            w_div0, w_ovf, w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_start = start_i & ~flush_i;
    // rs1 signed for MUL/MULH/MULHSU/DIV/REM; rs2 signed for MUL/MULH/DIV/REM.
    assign w_sgn1  = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'd3);
    assign w_sgn2  = op_i[2] ? ~op_i[0] : ~op_i[1];
    assign w_neg1  = w_sgn1 & reg1_i[XLEN-1];
    assign w_neg2  = w_sgn2 & reg2_i[XLEN-1];
    assign w_mag1  = w_neg1 ? -reg1_i : reg1_i;
    assign w_mag2  = w_neg2 ? -reg2_i : reg2_i;

    assign w_div0    = op_i[2] & (reg2_i == '0);
    assign w_ovf     = op_i[2] & ~op_i[0] & (reg1_i == {1'b1, {(XLEN-1){1'b0}}})
                     & (reg2_i == '1);
    assign w_special = w_div0 | w_ovf;
    // Divide by zero: quotient all ones, remainder rs1.
    // Overflow: quotient rs1, remainder zero.
    assign w_special_res = w_div0 ? (op_i[1] ? reg1_i : '1)
                                  : (op_i[1] ? '0 : reg1_i);

    // --------------------------------------------------- optional fast multiply
    logic            w_fast_mul;
    logic [XLEN-1:0] w_fast_res;
`ifdef BITTY_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa, w_fb;
    logic signed [2*XLEN-1:0] w_fa_ext, w_fb_ext, w_fp;
    assign w_fa       = {w_sgn1 & reg1_i[XLEN-1], reg1_i};
    assign w_fb       = {w_sgn2 & reg2_i[XLEN-1], reg2_i};
    assign w_fa_ext   = w_fa;
    assign w_fb_ext   = w_fb;
    assign w_fp       = w_fa_ext * w_fb_ext;
    assign w_fast_mul = ~op_i[2];
    assign w_fast_res = f_sel_mul(op_i[1:0], w_fp);
`else
    assign w_fast_mul = 1'b0;
    assign w_fast_res = '0;
`endif

    // ------------------------------------------------------ iterative datapath
    logic [XLEN:0]     w_hi_sum, w_rem_sh, w_rem_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_calc_res;

    // Multiply: add the multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    assign w_hi_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_nxt = {w_hi_sum, r_acc[XLEN-1:1]};

    // Divide: shift the next dividend bit into the partial remainder and
    // subtract; a clear borrow bit means the divisor fit.
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_rem_diff = w_rem_sh - {1'b0, r_a};
    assign w_ge       = ~w_rem_diff[XLEN];
    assign w_div_nxt  = {(w_ge ? w_rem_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_ge};

    assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

    // Sign fix-up applied to the value produced by the final step.
    assign w_prod = r_sign  ? -w_acc_nxt : w_acc_nxt;
    assign w_quo  = r_sign  ? -w_acc_nxt[XLEN-1:0]      : w_acc_nxt[XLEN-1:0];
    assign w_rem  = r_rsign ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
    assign w_calc_res = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                                : f_sel_mul(r_op[1:0], w_prod);

    // ------------------------------------------------------------------- FSM
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_stall     = 1'b1;
                    w_state_nxt = (w_special | w_fast_mul) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                w_stall = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // Flush or reset aborts immediately and releases the pipeline.
        if (flush_i | rst) begin
            w_state_nxt = S_IDLE;
            w_stall     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_acc   <= '0;
            r_sign  <= 1'b0;
            r_rsign <= 1'b0;
            r_done  <= 1'b0;
            r_wdata <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op    <= op_i;
                        r_wd    <= wd_i;
                        r_cnt   <= '0;
                        r_sign  <= w_neg1 ^ w_neg2;
                        r_rsign <= w_neg1;
                        // Mul keeps rs1 as multiplicand, shifts rs2 out of lo.
                        // Div keeps rs2 as divisor, shifts rs1 out of lo.
                        r_a     <= op_i[2] ? w_mag2 : w_mag1;
                        r_acc   <= {{XLEN{1'b0}}, (op_i[2] ? w_mag1 : w_mag2)};
                        if (w_special) begin
                            r_done  <= 1'b1;
                            r_wdata <= w_special_res;
                        end else if (w_fast_mul) begin
                            r_done  <= 1'b1;
                            r_wdata <= w_fast_res;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush_i) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_cnt_last) begin
                            r_done  <= 1'b1;
                            r_wdata <= w_calc_res;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign stallreq_o = w_stall;
    assign done_o     = r_done;
    assign wreg_o     = r_done;
    assign wdata_o    = r_wdata;
    assign wd_o       = r_wd;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_muldiv
//  Purpose  : Self-checking bench for ex_muldiv (XLEN = 32). Directed RV32M
//             cases, flush/reset aborts and randomized operations against a
//             64-bit arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

    localparam int XLEN      = 32;
    localparam int REGADDR_W = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start_i;
    logic [2:0]           op_i;
    logic [XLEN-1:0]      reg1_i;
    logic [XLEN-1:0]      reg2_i;
    logic [REGADDR_W-1:0] wd_i;
    logic                 flush_i;
    logic                 stallreq_o;
    logic                 done_o;
    logic [XLEN-1:0]      wdata_o;
    logic [REGADDR_W-1:0] wd_o;
    logic                 wreg_o;

    int n_checks = 0;
    int n_pass   = 0;

    ex_muldiv #(.XLEN(XLEN), .REGADDR_W(REGADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .flush_i    (flush_i),
        .stallreq_o (stallreq_o),
        .done_o     (done_o),
        .wdata_o    (wdata_o),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    endtask

    // RV32M semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if (op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
`ifdef BITTY_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation in an IDLE cycle and checks its completion.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd, input bit noise);
        int          k;
        int          lat;
        bit          stall_bad;
        logic [31:0] e_val;
        e_val = ref_model(op, a, b);
        lat   = exp_lat(op, a, b);
        @(negedge clk);
        start_i = 1'b1; op_i = op; reg1_i = a; reg2_i = b; wd_i = wd;
        #1 check($sformatf("op%0d stall_issue", op), stallreq_o, 1);
        @(posedge clk); #1;
        // Inputs change freely while the unit is busy; start_i must be ignored.
        start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        op_i = 3'($urandom); reg1_i = $urandom; reg2_i = $urandom; wd_i = 5'($urandom);
        k = 1;
        stall_bad = 1'b0;
        while (done_o !== 1'b1 && k < 80) begin
            if (stallreq_o !== 1'b1) stall_bad = 1'b1;
            if (noise) start_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
        end
        check($sformatf("op%0d latency", op), k, lat);
        check($sformatf("op%0d a=%h b=%h wdata", op, a, b), wdata_o, e_val);
        check($sformatf("op%0d wd", op), wd_o, wd);
        check($sformatf("op%0d wreg", op), wreg_o, 1);
        check($sformatf("op%0d stall_done", op), stallreq_o, 0);
        if (lat > 1) check($sformatf("op%0d stall_wait", op), stall_bad, 0);
        start_i = 1'b0;
        @(posedge clk); #1;
        check($sformatf("op%0d done_pulse", op), done_o, 0);
        check($sformatf("op%0d stall_idle", op), stallreq_o, 0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t dir[$];

    initial begin
        rst = 1'b1; start_i = 1'b0; op_i = '0; reg1_i = '0; reg2_i = '0;
        wd_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst done", done_o, 0);
        check("rst wreg", wreg_o, 0);
        check("rst wdata", wdata_o, 0);
        check("rst wd", wd_o, 0);
        check("rst stall", stallreq_o, 0);
        @(negedge clk); rst = 1'b0;

        dir.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD});
        dir.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF});
        dir.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF});
        dir.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2});
        dir.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2});
        dir.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2});
        dir.push_back('{3'd5, 32'd100,        32'd7});
        dir.push_back('{3'd7, 32'd100,        32'd7});
        dir.push_back('{3'd5, 32'd5,          32'd0});
        dir.push_back('{3'd7, 32'd5,          32'd0});
        dir.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF});
        dir.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF});
        foreach (dir[i]) run_op(dir[i].op, dir[i].a, dir[i].b, 5'(i + 1), 1'b0);

        // Flush during the tenth CALC cycle.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; reg1_i = 32'd1000; reg2_i = 32'd3; wd_i = 5'd20;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush_i = 1'b1;
        #1 check("flush stall", stallreq_o, 0);
        @(posedge clk); #1 flush_i = 1'b0;
        check("flush done", done_o, 0);
        check("flush wreg", wreg_o, 0);
        check("flush idle_stall", stallreq_o, 0);
        run_op(3'd5, 32'd9, 32'd3, 5'd21, 1'b0);

        // Reset during the fifth CALC cycle.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; reg1_i = 32'd12345; reg2_i = 32'd678; wd_i = 5'd9;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1 check("rstmid stall", stallreq_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        check("rstmid done", done_o, 0);
        check("rstmid wreg", wreg_o, 0);
        check("rstmid wdata", wdata_o, 0);
        check("rstmid wd", wd_o, 0);
        check("rstmid stall_after", stallreq_o, 0);
        run_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd11, 1'b0);
        run_op(3'd4, 32'hDEAD_BEEF, 32'h0000_0123, 5'd12, 1'b0);

        // Randomized operations with noise on start_i while busy.
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
